// File: rtl/name_buffer_pkg.sv
// Shared constants and types for the name/font writer and the glyph renderer.
package name_buffer_pkg;

  localparam int FONT_SIZE_W = 2;
  localparam int LEN_W       = 6;

  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] BS     = 8'h08;
  localparam logic [7:0] DEL    = 8'h7F;
  localparam logic [7:0] ESC    = 8'h1B;
  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] PLUS   = 8'h2B;
  localparam logic [7:0] MINUS  = 8'h2D;
  localparam logic [7:0] DIGIT0 = 8'h30;

  // Writer FSM: plain text editing, or waiting for the byte after ESC.
  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_ESC  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/name_buffer_writer_if.sv
// Byte channel from the UART receiver plus the frame timing pulse.
// With NAME_BUFFER_WRITER_ECHO_EN defined the channel also carries the
// echo transmit handshake (tx_data/tx_valid out of the writer, tx_ready in).
interface name_buffer_writer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_start;
`ifdef NAME_BUFFER_WRITER_ECHO_EN
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, output rx_valid, output frame_start,
                  input tx_data, input tx_valid, output tx_ready);
  modport slave  (input rx_data, input rx_valid, input frame_start,
                  output tx_data, output tx_valid, input tx_ready);
`else
  modport master (output rx_data, output rx_valid, output frame_start);
  modport slave  (input rx_data, input rx_valid, input frame_start);
`endif
endinterface

// File: rtl/name_char_classifier.sv
// Byte classification shared with the renderer so both sides agree on
// which codes are displayable text.
module name_char_classifier
  import name_buffer_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_printable,
  output logic       is_backspace,
  output logic       is_commit,
  output logic       is_escape,
  output logic       is_font_digit
);

  assign is_printable  = (code == SPACE) || (code == PLUS) || (code == MINUS) ||
                         ((code >= 8'h41) && (code <= 8'h5A)) ||
                         ((code >= 8'h61) && (code <= 8'h7A));
  assign is_backspace  = (code == BS) || (code == DEL);
  assign is_commit     = (code == CR);
  assign is_escape     = (code == ESC);
  assign is_font_digit = (code >= DIGIT0) && (code <= (DIGIT0 + 8'd3));

endmodule

// File: rtl/name_buffer_writer.sv
// Writer side of the name/font buffer: edits a shadow line from UART bytes,
// stages it on CR and publishes the staged line only on frame_start so the
// renderer never sees a half-updated name.
// Optional echo path: NAME_BUFFER_WRITER_ECHO_EN.
module name_buffer_writer
  import name_buffer_pkg::*;
#(
  parameter int MAX_NAME_LENGTH = 10
) (
  input  logic                         tft_clock_9m,
  input  logic                         system_reset_n,
  name_buffer_writer_if.slave          bus,
  output logic [8*MAX_NAME_LENGTH-1:0] name_buffer,
  output logic [LEN_W-1:0]             name_length,
  output logic [FONT_SIZE_W-1:0]       font_size,
  output logic                         update_pending,
  output logic                         overflow
);

  localparam int              BUF_W   = 8 * MAX_NAME_LENGTH;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_NAME_LENGTH);

  wr_state_t              state;
  logic [BUF_W-1:0]       shadow_buf_p0;
  logic [LEN_W-1:0]       shadow_len_p0;
  logic [FONT_SIZE_W-1:0] shadow_font_p0;
  logic [BUF_W-1:0]       stage_buf_p1;
  logic [LEN_W-1:0]       stage_len_p1;
  logic [FONT_SIZE_W-1:0] stage_font_p1;

  logic is_printable, is_backspace, is_commit, is_escape, is_font_digit;

  name_char_classifier u_classifier (
    .code          (bus.rx_data),
    .is_printable  (is_printable),
    .is_backspace  (is_backspace),
    .is_commit     (is_commit),
    .is_escape     (is_escape),
    .is_font_digit (is_font_digit)
  );

  // Edit FSM, shadow -> staging commit and staging -> output publish.
  // Publish is evaluated first so a same-cycle commit still overwrites
  // staging and re-arms update_pending.
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state          <= ST_EDIT;
      shadow_buf_p0  <= '0;
      shadow_len_p0  <= '0;
      shadow_font_p0 <= '0;
      stage_buf_p1   <= '0;
      stage_len_p1   <= '0;
      stage_font_p1  <= '0;
      update_pending <= 1'b0;
      overflow       <= 1'b0;
      name_buffer    <= '0;
      name_length    <= '0;
      font_size      <= '0;
    end else begin
      // shadow/staging -> display boundary
      if (bus.frame_start && update_pending) begin
        name_buffer    <= stage_buf_p1;
        name_length    <= stage_len_p1;
        font_size      <= stage_font_p1;
        update_pending <= 1'b0;
      end
      if (bus.rx_valid) begin
        case (state)
          ST_EDIT: begin
            if (is_printable) begin
              if (shadow_len_p0 < MAX_LEN) begin
                shadow_buf_p0[8*int'(shadow_len_p0) +: 8] <= bus.rx_data;
                shadow_len_p0 <= shadow_len_p0 + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else if (is_backspace) begin
              if (shadow_len_p0 != '0) begin
                shadow_buf_p0[8*(int'(shadow_len_p0)-1) +: 8] <= 8'h00;
                shadow_len_p0 <= shadow_len_p0 - 1'b1;
              end
            end else if (is_commit) begin
              stage_buf_p1   <= shadow_buf_p0;
              stage_len_p1   <= shadow_len_p0;
              stage_font_p1  <= shadow_font_p0;
              update_pending <= 1'b1;
              shadow_buf_p0  <= '0;
              shadow_len_p0  <= '0;
              overflow       <= 1'b0;
            end else if (is_escape) begin
              state <= ST_ESC;
            end
          end
          ST_ESC: begin
            if (is_font_digit) begin
              shadow_font_p0 <= bus.rx_data[FONT_SIZE_W-1:0];
            end
            state <= ST_EDIT;
          end
          default: state <= ST_EDIT;
        endcase
      end
    end
  end

`ifdef NAME_BUFFER_WRITER_ECHO_EN
  logic       echo_req;
  logic [7:0] echo_byte;

  // Echo only edits that actually take effect, plus CR on every commit.
  always_comb begin
    echo_req  = 1'b0;
    echo_byte = bus.rx_data;
    if (bus.rx_valid && (state == ST_EDIT)) begin
      if (is_printable && (shadow_len_p0 < MAX_LEN)) begin
        echo_req = 1'b1;
      end else if (is_backspace && (shadow_len_p0 != '0)) begin
        echo_req = 1'b1;
      end else if (is_commit) begin
        echo_req  = 1'b1;
        echo_byte = CR;
      end
    end
  end

  // One-entry holding register; a new echo is dropped while it is occupied.
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
    end else if (echo_req && (!bus.tx_valid || bus.tx_ready)) begin
      bus.tx_valid <= 1'b1;
      bus.tx_data  <= echo_byte;
    end else if (bus.tx_valid && bus.tx_ready) begin
      bus.tx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_name_buffer_writer.sv
// Directed plus randomized bench for name_buffer_writer against a
// queue-based model of the edit/commit/publish rules.
module tb_name_buffer_writer;
  import name_buffer_pkg::*;

  localparam int MAX = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  name_buffer_writer_if bus();

  logic [8*MAX-1:0]       name_buffer;
  logic [LEN_W-1:0]       name_length;
  logic [FONT_SIZE_W-1:0] font_size;
  logic                   update_pending;
  logic                   overflow;

  name_buffer_writer #(.MAX_NAME_LENGTH(MAX)) dut (
    .tft_clock_9m   (clk),
    .system_reset_n (rst_n),
    .bus            (bus),
    .name_buffer    (name_buffer),
    .name_length    (name_length),
    .font_size      (font_size),
    .update_pending (update_pending),
    .overflow       (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_shadow[$];
  logic [7:0] m_stage[$];
  logic [7:0] m_pub[$];
  int m_sfont, m_stage_font, m_pub_font;
  bit m_esc, m_pend, m_ovf;

  function automatic bit is_print(input logic [7:0] d);
    return (d == 8'h20) || (d == 8'h2B) || (d == 8'h2D) ||
           (d >= "A" && d <= "Z") || (d >= "a" && d <= "z");
  endfunction

  task automatic model_reset();
    m_shadow.delete(); m_stage.delete(); m_pub.delete();
    m_sfont = 0; m_stage_font = 0; m_pub_font = 0;
    m_esc = 0; m_pend = 0; m_ovf = 0;
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] d, input bit fs);
    if (fs && m_pend) begin
      m_pub = m_stage;
      m_pub_font = m_stage_font;
      m_pend = 0;
    end
    if (v) begin
      if (m_esc) begin
        if (d >= 8'h30 && d <= 8'h33) m_sfont = int'(d) - 'h30;
        m_esc = 0;
      end else if (is_print(d)) begin
        if (m_shadow.size() < MAX) m_shadow.push_back(d);
        else m_ovf = 1;
      end else if (d == 8'h08 || d == 8'h7F) begin
        if (m_shadow.size() > 0) void'(m_shadow.pop_back());
      end else if (d == 8'h0D) begin
        m_stage = m_shadow;
        m_stage_font = m_sfont;
        m_pend = 1;
        m_shadow.delete();
        m_ovf = 0;
      end else if (d == 8'h1B) begin
        m_esc = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [8*MAX-1:0] e;
    e = '0;
    foreach (m_pub[i]) e[8*i +: 8] = m_pub[i];
    check({tag, ".buf"}, 128'(name_buffer), 128'(e));
    check({tag, ".len"}, 128'(name_length), 128'(m_pub.size()));
    check({tag, ".font"}, 128'(font_size), 128'(m_pub_font));
    check({tag, ".pend"}, 128'(update_pending), 128'(m_pend));
    check({tag, ".ovf"}, 128'(overflow), 128'(m_ovf));
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit fs);
    bus.rx_valid = v;
    bus.rx_data = d;
    bus.frame_start = fs;
    @(posedge clk);
    model_cycle(v, d, fs);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], 1'b0);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.frame_start = 1'b0;
`ifdef NAME_BUFFER_WRITER_ECHO_EN
    bus.tx_ready = 1'b1;
`endif
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // "Ab+" CR then publish
    send_str("Ab+");
    cycle(1'b1, CR, 1'b0);
    check_model("t1.staged");
    check("t1.pend_set", 128'(update_pending), 128'(1));
    cycle(1'b0, 8'h00, 1'b1);
    check_model("t1.pub");
    check("t1.low24", 128'(name_buffer[23:0]), 128'(24'h2B6241));
    check("t1.len3", 128'(name_length), 128'(3));
    check("t1.pend_clr", 128'(update_pending), 128'(0));

    // Font change, commit without frame_start
    cycle(1'b1, ESC, 1'b0);
    send_str("2Hi");
    cycle(1'b1, CR, 1'b0);
    check_model("t2.held");
    check("t2.len_held", 128'(name_length), 128'(3));
    cycle(1'b0, 8'h00, 1'b1);
    check_model("t2.pub");
    check("t2.font2", 128'(font_size), 128'(2));
    check("t2.len2", 128'(name_length), 128'(2));

    // Overflow at capacity
    send_str("ABCDEFGHIJ");
    check_model("t3.full");
    cycle(1'b1, "K", 1'b0);
    check("t3.ovf11", 128'(overflow), 128'(1));
    cycle(1'b1, "L", 1'b0);
    check_model("t3.ovf12");
    cycle(1'b1, CR, 1'b0);
    check("t3.ovf_clr", 128'(overflow), 128'(0));
    cycle(1'b0, 8'h00, 1'b1);
    check_model("t3.pub");
    check("t3.len10", 128'(name_length), 128'(10));

    // Backspace past empty
    send_str("abc");
    cycle(1'b1, BS, 1'b0);
    cycle(1'b1, DEL, 1'b0);
    cycle(1'b1, BS, 1'b0);
    cycle(1'b1, BS, 1'b0);
    cycle(1'b1, CR, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check_model("t4.pub");
    check("t4.len0", 128'(name_length), 128'(0));
    check("t4.blank", 128'(name_buffer), 128'(0));

    // Commit coinciding with frame_start while pending
    send_str("X");
    cycle(1'b1, CR, 1'b0);
    send_str("YZ");
    cycle(1'b1, CR, 1'b1);
    check_model("t5.race");
    check("t5.lenX", 128'(name_length), 128'(1));
    check("t5.pend_kept", 128'(update_pending), 128'(1));
    cycle(1'b0, 8'h00, 1'b1);
    check_model("t5.next");
    check("t5.lenYZ", 128'(name_length), 128'(2));

    // Reset while pending and inside ESC
    send_str("Q");
    cycle(1'b1, CR, 1'b0);
    cycle(1'b1, ESC, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("t6.in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_str("1B");
    cycle(1'b1, CR, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check_model("t6.after");
    check("t6.font0", 128'(font_size), 128'(0));
    check("t6.lenB", 128'(name_length), 128'(1));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      int r;
      bit v, fs;
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2, 3, 4, 5, 6, 7: d = 8'(8'h41 + $urandom_range(0, 25));
        8:  d = 8'(8'h61 + $urandom_range(0, 25));
        9:  begin
              int k;
              k = $urandom_range(0, 2);
              d = (k == 0) ? SPACE : (k == 1) ? PLUS : MINUS;
            end
        10: d = ($urandom_range(0, 1) == 0) ? BS : DEL;
        11: d = CR;
        12: d = ESC;
        13: d = 8'(8'h30 + $urandom_range(0, 5));
        14: d = LF;
        default: d = 8'($urandom_range(0, 255));
      endcase
      v = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 7) == 0);
      cycle(v, d, fs);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
